tamagotchi_btn_cond: RTL and testbench

- Conditions the six raw push-buttons and produces the clean single-cycle command pulses consumed by tamagotchi_fsm.
- Sits directly upstream of the FSM and drives its btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset and btn_test inputs.
- Per button: synchronises, debounces, edge-detects, and applies priority arbitration.
- Reset and test are long-press-only commands, so an accidental tap never resets the pet or enters test mode.

---
 rtl/tamagotchi_btn_cond.sv | 126 ++++++++++++
 tb/tb_tamagotchi_btn_cond.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_btn_cond.sv
// Button conditioner for tamagotchi_fsm: sync, debounce, edge/long-press
// detection and fixed-priority arbitration into single-cycle command pulses.
module tamagotchi_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int LONG_CYCLES     = 10,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_salud,
    input  logic raw_energia,
    input  logic raw_hambre,
    input  logic raw_diversion,
    input  logic raw_reset,
    input  logic raw_test,
    output logic btn_salud,
    output logic btn_energia,
    output logic btn_hambre,
    output logic btn_diversion,
    output logic btn_reset,
    output logic btn_test,
    output logic btn_conflict
);

    localparam int NB = 6;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

    // Bit index doubles as priority rank: 0 = reset (highest) .. 5 = diversion.
    logic [NB-1:0] raw_vec;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_q;
    logic [DW-1:0] db_cnt [NB];
    logic [LW-1:0] hold_cnt [2];
    logic [1:0]    fired;
    logic [NB-1:0] cand;
    logic [NB-1:0] grant;

    assign raw_vec = {raw_diversion, raw_hambre, raw_energia,
                      raw_salud, raw_test, raw_reset} ^ {NB{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Hold counters saturate; fired blocks repeats until release.
    always_ff @(posedge clk) begin
        if (reset) begin
            fired <= '0;
            for (int j = 0; j < 2; j++) begin
                hold_cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!deb[j]) begin
                    hold_cnt[j] <= '0;
                    fired[j]    <= 1'b0;
                end else begin
                    if (hold_cnt[j] != LONG_MAX) begin
                        hold_cnt[j] <= hold_cnt[j] + LW'(1);
                    end
                    if (cand[j]) begin
                        fired[j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cand[NB-1:2] = deb[NB-1:2] & ~deb_q[NB-1:2];
        for (int j = 0; j < 2; j++) begin
            cand[j] = (hold_cnt[j] == LONG_MAX) && !fired[j];
        end
    end

    // Lowest set bit wins.
    assign grant = cand & (~cand + NB'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_reset     <= 1'b0;
            btn_test      <= 1'b0;
            btn_salud     <= 1'b0;
            btn_energia   <= 1'b0;
            btn_hambre    <= 1'b0;
            btn_diversion <= 1'b0;
            btn_conflict  <= 1'b0;
        end else begin
            btn_reset     <= grant[0];
            btn_test      <= grant[1];
            btn_salud     <= grant[2];
            btn_energia   <= grant[3];
            btn_hambre    <= grant[4];
            btn_diversion <= grant[5];
            btn_conflict  <= |(cand & ~grant);
        end
    end

endmodule

// File: tb/tb_tamagotchi_btn_cond.sv
// Bench for tamagotchi_btn_cond: directed vector table, hand sequences and
// random stimulus against a history-based reference model.
module tb_tamagotchi_btn_cond;

    localparam int D    = 5;
    localparam int L    = 10;
    localparam int MAXC = 4096;

    // raw bits: [5]reset [4]test [3]salud [2]energia [1]hambre [0]diversion
    localparam logic [5:0] R_RST = 6'b100000;
    localparam logic [5:0] R_TST = 6'b010000;
    localparam logic [5:0] R_SAL = 6'b001000;
    localparam logic [5:0] R_ENE = 6'b000100;
    localparam logic [5:0] R_HAM = 6'b000010;
    localparam logic [5:0] R_DIV = 6'b000001;
    // out bits: [6]reset [5]test [4]salud [3]energia [2]hambre [1]diversion [0]conflict
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_RST  = 7'b1000000;
    localparam logic [6:0] O_SAL  = 7'b0010000;
    localparam logic [6:0] O_ENE  = 7'b0001000;
    localparam logic [6:0] O_HAM  = 7'b0000100;
    localparam logic [6:0] O_CONF = 7'b0000001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] raw = '0;
    wire [6:0] out_a;
    wire [6:0] out_b;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tamagotchi_btn_cond #(
        .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)
    ) u_hi (
        .clk(clk), .reset(reset),
        .raw_salud(raw[3]), .raw_energia(raw[2]),
        .raw_hambre(raw[1]), .raw_diversion(raw[0]),
        .raw_reset(raw[5]), .raw_test(raw[4]),
        .btn_salud(out_a[4]), .btn_energia(out_a[3]),
        .btn_hambre(out_a[2]), .btn_diversion(out_a[1]),
        .btn_reset(out_a[6]), .btn_test(out_a[5]),
        .btn_conflict(out_a[0])
    );

    tamagotchi_btn_cond #(
        .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)
    ) u_lo (
        .clk(clk), .reset(reset),
        .raw_salud(~raw[3]), .raw_energia(~raw[2]),
        .raw_hambre(~raw[1]), .raw_diversion(~raw[0]),
        .raw_reset(~raw[5]), .raw_test(~raw[4]),
        .btn_salud(out_b[4]), .btn_energia(out_b[3]),
        .btn_hambre(out_b[2]), .btn_diversion(out_b[1]),
        .btn_reset(out_b[6]), .btn_test(out_b[5]),
        .btn_conflict(out_b[0])
    );

    // Model keeps full per-edge history; button b: 0=reset .. 5=diversion.
    logic samp [6][MAXC];
    logic debv [6][MAXC];
    logic rstv [MAXC];
    int n = 0;

    function automatic logic sget(int b, int i);
        return (i < 0) ? 1'b0 : samp[b][i];
    endfunction

    function automatic logic dget(int b, int i);
        return (i < 0) ? 1'b0 : debv[b][i];
    endfunction

    function automatic logic rget(int i);
        return (i < 0) ? 1'b0 : rstv[i];
    endfunction

    task automatic check(input string name, input logic [6:0] act,
                         input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge %0d: got %b want %b", name, n - 1, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [5:0] rw,
                              output logic [6:0] exp);
        logic [5:0] cand;
        int cnt;
        bit won;
        exp = '0;
        cand = '0;
        if (n >= MAXC) begin
            $display("FAIL model_capacity edge %0d: got %0d want <%0d", n, n, MAXC);
            $fatal(1, "model history exhausted");
        end
        rstv[n] = r;
        for (int b = 0; b < 6; b++) begin
            if (r) begin
                samp[b][n] = 1'b0;
                if (n > 0) samp[b][n-1] = 1'b0;
                debv[b][n] = 1'b0;
            end else begin
                logic cur;
                bit flip;
                samp[b][n] = rw[5-b];
                cur = dget(b, n - 1);
                flip = 1'b1;
                for (int k = 0; k < D; k++) begin
                    if (sget(b, n - 2 - k) == cur) flip = 1'b0;
                end
                debv[b][n] = flip ? ~cur : cur;
            end
        end
        if (!r && !rget(n - 1)) begin
            for (int b = 2; b < 6; b++) begin
                cand[b] = dget(b, n - 1) & ~dget(b, n - 2);
            end
            for (int b = 0; b < 2; b++) begin
                int run;
                int i;
                run = 0;
                i = n - 2;
                while (i >= 0 && run <= L && dget(b, i)) begin
                    run++;
                    i--;
                end
                cand[b] = (run == L);
            end
        end
        cnt = 0;
        won = 1'b0;
        for (int b = 0; b < 6; b++) begin
            if (cand[b]) begin
                cnt++;
                if (!won) begin
                    exp[6-b] = 1'b1;
                    won = 1'b1;
                end
            end
        end
        exp[0] = (cnt > 1);
        n++;
    endtask

    task automatic step(input logic r, input logic [5:0] rw);
        logic [6:0] exp_m;
        @(negedge clk);
        reset = r;
        raw = rw;
        @(posedge clk);
        #1;
        model_edge(r, rw, exp_m);
        check("model_hi", out_a, exp_m);
        check("model_lo", out_b, exp_m);
    endtask

    task automatic expect_both(input string name, input logic [6:0] want);
        check({name, "_hi"}, out_a, want);
        check({name, "_lo"}, out_b, want);
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] raw;
        int         len;
        int         hit_at;
        logic [6:0] hit_val;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1'b1, 6'b0,   2,  -1, O_NONE});
        tbl.push_back('{1'b0, 6'b0,   5,  -1, O_NONE});
        tbl.push_back('{1'b0, R_SAL,  3,  -1, O_NONE});
        tbl.push_back('{1'b0, 6'b0,   12, -1, O_NONE});
        tbl.push_back('{1'b0, R_HAM,  20, 7,  O_HAM});
        tbl.push_back('{1'b0, 6'b0,   15, -1, O_NONE});
        tbl.push_back('{1'b0, R_TST,  8,  -1, O_NONE});
        tbl.push_back('{1'b0, 6'b0,   20, -1, O_NONE});
        tbl.push_back('{1'b0, R_RST,  30, 17, O_RST});
        tbl.push_back('{1'b0, 6'b0,   15, -1, O_NONE});
        tbl.push_back('{1'b0, R_RST,  30, 17, O_RST});
        tbl.push_back('{1'b0, 6'b0,   15, -1, O_NONE});
        tbl.push_back('{1'b0, R_ENE | R_DIV, 20, 7, O_ENE | O_CONF});
        tbl.push_back('{1'b0, 6'b0,   15, -1, O_NONE});
        tbl.push_back('{1'b0, R_SAL,  4,  -1, O_NONE});
        tbl.push_back('{1'b1, R_SAL,  1,  -1, O_NONE});
        tbl.push_back('{1'b0, R_SAL,  20, 7,  O_SAL});
        tbl.push_back('{1'b0, 6'b0,   15, -1, O_NONE});

        foreach (tbl[v]) begin
            for (int c = 0; c < tbl[v].len; c++) begin
                step(tbl[v].rst, tbl[v].raw);
                expect_both($sformatf("vec%0d_c%0d", v, c),
                            (c == tbl[v].hit_at) ? tbl[v].hit_val : O_NONE);
            end
        end

        // Salud pulse lands on the same cycle as the reset long-press.
        for (int c = 0; c < 45; c++) begin
            logic [5:0] rw;
            rw = '0;
            if (c < 30) rw = R_RST | ((c >= 10) ? R_SAL : 6'b0);
            step(1'b0, rw);
            expect_both($sformatf("rst_vs_sal_c%0d", c),
                        (c == 17) ? (O_RST | O_CONF) : O_NONE);
        end

        // Reset and test long-pressed together: test is dropped for good.
        for (int c = 0; c < 40; c++) begin
            step(1'b0, (c < 25) ? (R_RST | R_TST) : 6'b0);
            expect_both($sformatf("rst_vs_tst_c%0d", c),
                        (c == 17) ? (O_RST | O_CONF) : O_NONE);
        end

        begin
            logic [5:0] rw;
            rw = '0;
            for (int c = 0; c < 3000; c++) begin
                logic r;
                for (int b = 0; b < 6; b++) begin
                    if ($urandom_range(0, 17) == 0) rw[b] = ~rw[b];
                end
                r = ($urandom_range(0, 399) == 0);
                step(r, rw);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
